// File: rtl/crc_pkg.sv
// Shared CRC constants, FSM state type and the single-byte MSB-first CRC step.
package crc_pkg;

  localparam logic [31:0] CRC32_MPEG2_POLY = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT       = 32'hFFFFFFFF;

  typedef enum logic {ACCUM = 1'b0, RESULT = 1'b1} state_e;

  // Advance a 32-bit CRC by one byte, MSB first, no reflection.
  function automatic logic [31:0] crc_byte_step(input logic [31:0] crc,
                                                input logic [7:0]  data_byte,
                                                input logic [31:0] poly);
    logic [31:0] c;
    logic        fb;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      fb = c[31] ^ data_byte[7-i];
      c  = {c[30:0], 1'b0} ^ (poly & {32{fb}});
    end
    return c;
  endfunction

endpackage

// File: rtl/crc32_beat_update.sv
// Combinational CRC update over the leading nbytes bytes of one beat.
module crc32_beat_update
  import crc_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NB     = DATA_W / 8,
  parameter int NBW    = $clog2(NB) + 1
) (
  input  logic [31:0]       crc_in,
  input  logic [DATA_W-1:0] data,
  input  logic [NBW-1:0]    nbytes,
  input  logic [31:0]       poly,
  output logic [31:0]       crc_out
);

  logic [NB:0][31:0] chain;

  assign chain[0] = crc_in;

  // Unrolled byte chain; byte 0 is the top byte of the beat (first on the wire).
  // Bytes at or beyond nbytes pass the CRC through, so nbytes > NB means all bytes.
  for (genvar i = 0; i < NB; i++) begin : g_byte
    assign chain[i+1] = (NBW'(i) < nbytes)
                        ? crc_byte_step(chain[i], data[DATA_W-1-8*i -: 8], poly)
                        : chain[i];
  end

  assign crc_out = chain[NB];

endmodule

// File: rtl/crc32_stream_engine.sv
// Streaming CRC-32 engine: accumulates over a multi-beat frame, presents the
// finished CRC and byte length on a held valid/ready result port.
module crc32_stream_engine
  import crc_pkg::*;
#(
  parameter int          DATA_W  = 32,
  parameter logic [31:0] POLY    = CRC32_MPEG2_POLY,
  parameter logic [31:0] INIT    = CRC32_INIT,
  parameter logic [31:0] XOR_OUT = 32'h00000000,
  parameter int          LEN_W   = 16,
  localparam int         NB      = DATA_W / 8,
  localparam int         NBW     = $clog2(NB) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  input  logic [NBW-1:0]    s_bytes,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [31:0]       m_crc,
  output logic [LEN_W-1:0]  m_len
);

  state_e             state, state_nxt;
  logic [31:0]        crc_reg;
  logic [31:0]        crc_next;
  logic [LEN_W-1:0]   len_cnt;
  logic [NBW-1:0]     nb_sel;
  logic [NBW-1:0]     nb_used;
  logic               accept;

  assign s_ready = (state == ACCUM) && !clear;
  assign m_valid = (state == RESULT);
  assign accept  = s_valid && s_ready;

  // Full beats step every byte; a last beat steps only its leading s_bytes.
  assign nb_sel  = s_last ? s_bytes : NBW'(NB);
  assign nb_used = (nb_sel > NBW'(NB)) ? NBW'(NB) : nb_sel;

  crc32_beat_update #(.DATA_W(DATA_W)) u_beat (
    .crc_in  (crc_reg),
    .data    (s_data),
    .nbytes  (nb_used),
    .poly    (POLY),
    .crc_out (crc_next)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACCUM;
    else        state <= state_nxt;
  end

  // Next state: clear wins, otherwise last-beat enters RESULT, handshake leaves it.
  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = ACCUM;
    end else begin
      case (state)
        ACCUM:   if (accept && s_last) state_nxt = RESULT;
        RESULT:  if (m_ready)          state_nxt = ACCUM;
        default: state_nxt = ACCUM;
      endcase
    end
  end

  // Accumulator, length counter and held result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_reg <= INIT;
      len_cnt <= '0;
      m_crc   <= '0;
      m_len   <= '0;
    end else if (clear) begin
      crc_reg <= INIT;
      len_cnt <= '0;
    end else if (accept) begin
      if (s_last) begin
        m_crc   <= crc_next ^ XOR_OUT;
        m_len   <= len_cnt + LEN_W'(nb_used);
        crc_reg <= INIT;
        len_cnt <= '0;
      end else begin
        crc_reg <= crc_next;
        len_cnt <= len_cnt + LEN_W'(NB);
      end
    end
  end

endmodule

// File: tb/tb_crc32_stream_engine.sv
// Scoreboard bench for crc32_stream_engine: directed frames plus randomized traffic.
module tb_crc32_stream_engine;

  localparam int DATA_W = 32;
  localparam int NB     = DATA_W / 8;
  localparam int NBW    = $clog2(NB) + 1;
  localparam int LEN_W  = 16;
  localparam logic [31:0] CHECK = 32'h0376E6E7;

  typedef struct packed {
    logic [31:0]      crc;
    logic [LEN_W-1:0] len;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              clear = 1'b0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [DATA_W-1:0] s_data = '0;
  logic              s_last = 1'b0;
  logic [NBW-1:0]    s_bytes = '0;
  logic              m_valid;
  logic              m_ready = 1'b1;
  logic [31:0]       m_crc;
  logic [LEN_W-1:0]  m_len;

  logic [31:0]       bu_in = '0;
  logic [DATA_W-1:0] bu_data = '0;
  logic [NBW-1:0]    bu_nb = '0;
  logic [31:0]       bu_out;

  int   tests_run = 0;
  int   tests_failed = 0;
  bit   rand_ready = 1'b0;
  exp_t exp_q[$];
  logic [7:0] frame_q[$];

  crc32_stream_engine #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .s_bytes(s_bytes),
    .m_valid(m_valid), .m_ready(m_ready), .m_crc(m_crc), .m_len(m_len)
  );

  crc32_beat_update #(.DATA_W(DATA_W)) u_bu (
    .crc_in(bu_in), .data(bu_data), .nbytes(bu_nb),
    .poly(32'h04C11DB7), .crc_out(bu_out)
  );

  always #5 clk = ~clk;

  // Textbook MSB-first CRC over a byte list.
  function automatic logic [31:0] ref_crc(input logic [31:0] init, input logic [7:0] bytes[$]);
    logic [31:0] c;
    c = init;
    foreach (bytes[k]) begin
      c ^= {bytes[k], 24'h0};
      for (int b = 0; b < 8; b++)
        c = c[31] ? ((c << 1) ^ 32'h04C11DB7) : (c << 1);
    end
    return c;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: every result handshake is compared against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      exp_t e;
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL result_unexpected: got crc %0h len %0d with empty scoreboard", m_crc, m_len);
      end else begin
        e = exp_q.pop_front();
        if (m_crc !== e.crc || m_len !== e.len) begin
          tests_failed++;
          $display("FAIL result: got crc %0h len %0d expected crc %0h len %0d",
                   m_crc, m_len, e.crc, e.len);
        end
      end
    end
  end

  // Random result backpressure when enabled.
  always @(posedge clk) begin
    #1;
    if (rand_ready) m_ready = ($urandom_range(0, 3) != 0);
  end

  // Issue one beat, wait for its handshake, and update the frame model.
  task automatic send_beat(input logic [DATA_W-1:0] d, input logic last, input int nb);
    int  n;
    bit  done;
    exp_t e;
    s_valid = 1'b1; s_data = d; s_last = last; s_bytes = NBW'(nb);
    done = 1'b0;
    for (int t = 0; t < 300 && !done; t++) begin
      @(negedge clk);
      done = s_ready;
      @(posedge clk); #1;
    end
    s_valid = 1'b0; s_last = 1'b0;
    if (!done) begin
      check("beat_accept_timeout", 64'd0, 64'd1);
      return;
    end
    n = last ? ((nb > NB) ? NB : nb) : NB;
    for (int k = 0; k < n; k++) frame_q.push_back(d[DATA_W-1-8*k -: 8]);
    if (last) begin
      e.crc = ref_crc(32'hFFFFFFFF, frame_q);
      e.len = LEN_W'(frame_q.size());
      exp_q.push_back(e);
      frame_q.delete();
    end
  endtask

  task automatic send_check_string();
    send_beat(32'h31323334, 1'b0, 0);
    send_beat(32'h35363738, 1'b0, 0);
    send_beat(32'h39000000, 1'b1, 1);
  endtask

  task automatic drain();
    for (int t = 0; t < 500 && exp_q.size() != 0; t++) @(posedge clk);
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    // Combinational beat update against the reference, random init and byte count.
    for (int i = 0; i < 24; i++) begin
      logic [7:0] bq[$];
      int n;
      bu_in = $urandom; bu_data = $urandom;
      bu_nb = (i < 12) ? NBW'(NB) : NBW'($urandom_range(0, 7));
      n = (int'(bu_nb) > NB) ? NB : int'(bu_nb);
      bq.delete();
      for (int k = 0; k < n; k++) bq.push_back(bu_data[DATA_W-1-8*k -: 8]);
      #1;
      check("beat_update", 64'(bu_out), 64'(ref_crc(bu_in, bq)));
    end

    // Reset state.
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_s_ready", 64'(s_ready), 64'd1);
    check("rst_m_crc",   64'(m_crc),   64'd0);
    check("rst_m_len",   64'(m_len),   64'd0);
    @(posedge clk); #1;

    // Check string, scoreboard against the known constant as well.
    send_check_string();
    check("check_string_model", 64'(exp_q[exp_q.size()-1].crc), 64'(CHECK));
    drain();

    // Zero-length frame and one-cycle latency.
    send_beat(32'hA5A5A5A5, 1'b1, 0);
    check("zero_len_model", 64'(exp_q[exp_q.size()-1].crc), 64'hFFFFFFFF);
    check("zero_len_latency", 64'(m_valid), 64'd1);
    drain();

    // Backpressure: result held five cycles with input stalled.
    m_ready = 1'b0;
    send_check_string();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_m_valid", 64'(m_valid), 64'd1);
      check("bp_m_crc",   64'(m_crc),   64'(CHECK));
      check("bp_m_len",   64'(m_len),   64'd9);
      check("bp_s_ready", 64'(s_ready), 64'd0);
      @(posedge clk); #1;
    end
    m_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_m_valid", 64'(m_valid), 64'd0);
    check("bp_release_s_ready", 64'(s_ready), 64'd1);
    send_check_string();
    drain();

    // Clear mid-frame: partial frame and the beat under clear are discarded.
    send_beat(32'h31323334, 1'b0, 0);
    clear = 1'b1; s_valid = 1'b1; s_data = 32'hDEADBEEF;
    @(negedge clk);
    check("clear_s_ready", 64'(s_ready), 64'd0);
    @(posedge clk); #1;
    clear = 1'b0; s_valid = 1'b0;
    frame_q.delete();
    send_check_string();
    check("clear_model", 64'(exp_q[exp_q.size()-1].crc), 64'(CHECK));
    drain();

    // Async reset while a result is pending.
    m_ready = 1'b0;
    send_check_string();
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("arst_m_valid", 64'(m_valid), 64'd0);
    check("arst_m_crc",   64'(m_crc),   64'd0);
    check("arst_m_len",   64'(m_len),   64'd0);
    void'(exp_q.pop_back());
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_ready = 1'b1;
    @(negedge clk);
    check("arst_s_ready", 64'(s_ready), 64'd1);
    @(posedge clk); #1;
    send_check_string();
    drain();

    // Randomized frames with idle gaps and result backpressure.
    rand_ready = 1'b1;
    for (int f = 0; f < 40; f++) begin
      int nbeats;
      nbeats = $urandom_range(1, 6);
      for (int b = 0; b < nbeats; b++) begin
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #0;
        if (b == nbeats - 1) send_beat($urandom, 1'b1, $urandom_range(0, 7));
        else                 send_beat($urandom, 1'b0, 0);
      end
    end
    drain();
    rand_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
